// File: rtl/fifo_reader.sv
// Pops words from the attached FIFO and sends each as a start/LSB-first-data/stop serial frame.
// Pop-to-start latency is 2 cycles; no backpressure: `enable` gates only the start of a new frame.
`timescale 1ns/1ps
module fifo_reader #(
    parameter int N   = 4,
    parameter int M   = 2,
    parameter int DIV = 4,
    parameter int CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          push,
    input  logic          full,
    input  logic [M-1:0]  rd_data,
    output logic          pop,
    output logic          tx,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          sync_err
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]    state, state_nx;
    logic [DW-1:0] div_cnt, div_nx;
    logic [BW-1:0] bit_cnt, bit_nx;
    logic [M-1:0]  shift, shift_nx;
    logic          div_end;
    logic          acc;
    logic [CW-1:0] count_nx;

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        div_end  = (div_cnt == DW'(DIV - 1));
        case (state)
            IDLE:  if (enable && count != '0) state_nx = POP;
            POP:   state_nx = LOAD;
            LOAD: begin
                shift_nx = rd_data;
                div_nx   = '0;
                bit_nx   = '0;
                state_nx = START;
            end
            START: begin
                if (div_end) begin
                    div_nx   = '0;
                    state_nx = DATA;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            DATA: begin
                if (div_end) begin
                    div_nx   = '0;
                    shift_nx = shift >> 1;
                    bit_nx   = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(M - 1)) state_nx = STOP;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            STOP: begin
                if (div_end) begin
                    div_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A push is accepted when there is room, or when a pop frees a slot in the same cycle.
    assign acc      = push && (count < CW'(N) || pop);
    assign count_nx = count + CW'(acc) - CW'(pop);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            pop      <= 1'b0;
            tx       <= 1'b1;
            count    <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
            shift    <= shift_nx;
            // tx and pop are registered from next-state values so they line up with the state.
            pop      <= (state_nx == POP);
            tx       <= (state_nx == START) ? 1'b0 :
                        (state_nx == DATA)  ? shift_nx[0] : 1'b1;
            count    <= count_nx;
            sync_err <= sync_err | (full != (count == CW'(N)));
        end
    end
endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side companion to the word-queue FIFO. It tracks queue occupancy from the upstream push strobe, because the FIFO itself exposes only `full`. It pops one word at a time and transmits each word LSB-first on a single-wire framed serial line: start bit 0, M data bits, stop bit 1, idle high. It sits between the FIFO's read port and the off-block serial link.

## Interface
- `N`, 4: FIFO depth in words; must equal the attached FIFO's `N`.
- `M`, 2: word width in bits; must equal the FIFO's `M`.
- `DIV`, 4: clock cycles per serial bit; legal range ≥1.
- `CW`, $clog2(N+1): width of `count`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `enable`  in  1  permits a new frame to start; it never aborts a frame in progress.
- `push`  in  1  copy of the upstream push strobe driven into the FIFO.
- `full`  in  1  FIFO full flag.
- `rd_data`  in  M  FIFO read data; valid in the cycle after `pop`.
- `pop`  out  1  registered pop strobe to the FIFO; one-cycle pulse.
- `tx`  out  1  serial output; idle level 1.
- `busy`  out  1  high in any state other than IDLE.
- `count`  out  CW  tracked occupancy, range 0..N.
- `sync_err`  out  1  sticky; set when `full` disagrees with `count==N`.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. If `enable && count!=0`, go to POP.
- POP: `pop`=1 for exactly this cycle, then go to LOAD.
- LOAD: capture `rd_data` into the shift register. Clear the bit counter and the divider. Go to START.
- START: `tx`=0 for DIV cycles, then go to DATA.
- DATA: `tx`=shift[0] for DIV cycles per bit. After each bit, shift right and increment the bit counter. After M bits, go to STOP.
- STOP: `tx`=1 for DIV cycles, then go to IDLE.
- IDLE is held for at least one cycle between frames.
- Occupancy: `count_next = count + acc - pop`, where `acc = push && (count<N || pop)`.
  - A push while full with no pop is ignored, matching the FIFO.
  - A push and a pop in the same cycle leave `count` unchanged.
- `count` never underflows. `pop` is issued only when `count`≥1.
- `sync_err`:
  - Set in any cycle, outside the reset cycle, where `full != (count==N)`.
  - Cleared only by `reset`.
- Reset values: `pop`=0, `tx`=1, `busy`=0, `count`=0, `sync_err`=0, state IDLE, shift register 0.
- Reset mid-frame: the frame is abandoned. `tx` is 1 from the next cycle. The popped word is lost, and no further pop occurs for it.
- `enable` deasserted mid-frame: the current frame completes normally, and no new POP is taken.
- `push` during a frame only updates `count`.

## Timing
- Let cycle P be the cycle in which `pop`=1.
  - IDLE decision in cycle P-1.
  - `rd_data` is sampled at the end of cycle P+1.
  - `tx`=0 during cycles P+2 .. P+1+DIV.
  - Data bit i is on `tx` during cycles P+2+(i+1)·DIV .. P+1+(i+2)·DIV.
  - The stop bit ends at cycle P+1+(M+2)·DIV.
  - IDLE is in cycle P+2+(M+2)·DIV.
  - The earliest next `pop` is in cycle P+3+(M+2)·DIV.
- Back-to-back frame period: (M+2)·DIV+3 cycles.
- `count` reflects a push or pop in the cycle after the strobe. `full` is compared against that same registered `count`.
- `tx` and `pop` are driven directly from flops, with no combinational path from any input.

## Test plan
- Reset, then N=4, M=2, DIV=4:
  - Push 2'b10 in cycle 0.
  - `count`=1 in cycle 1.
  - `pop` in cycle 2.
  - `tx` pattern from cycle 4: 0×4, 0×4, 1×4, 1×4.
  - `busy` falls at cycle 20.
- Push 4 words (01, 10, 11, 00) with `enable`=0:
  - `count`=4 and `full`=1, with `sync_err`=0.
  - A 5th push leaves `count`=4.
  - Raising `enable` yields 4 frames with 19-cycle spacing, in order 01, 10, 11, 00.
- Simultaneous push and pop at `count`=4: `count` stays 4, and the pushed word is transmitted 4th after that pop.
- Assert `reset` during the DATA state:
  - Next cycle `tx`=1, `busy`=0, `count`=0, no `pop`.
  - A subsequent push then produces a clean frame.
- Force `full`=1 while `count`=2: `sync_err` is 1 next cycle and stays 1 until `reset`.
- DIV=1, M=2, 3 words queued: 7-cycle frame period; `tx` is never low during a stop bit.
